// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the multi-port RAM
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_IDLE} ram_state_t;

  // Widest word byte_merge can handle; callers zero-extend into it and truncate back.
  localparam int RAM_MAX_W = 256;

  function automatic int ram_lanes(input int width, input int byte_w);
    return width / byte_w;
  endfunction

  function automatic logic [RAM_MAX_W-1:0] byte_merge(
    input logic [RAM_MAX_W-1:0] old_w,
    input logic [RAM_MAX_W-1:0] new_w,
    input logic [RAM_MAX_W-1:0] be,
    input int                   byte_w
  );
    logic [RAM_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < RAM_MAX_W; i++) begin
      if (be[i/byte_w]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// rtl/ram_clr_ctrl.sv - clear-engine FSM that sweeps zeroes over the whole array
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_we,
  output logic [WORD_SIZE-1:0] clr_addr
);

  ram_state_t           state_q, state_d;
  logic [WORD_SIZE-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RAM_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = ptr_q;
    case (state_q)
      RAM_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = RAM_IDLE;
      end
      RAM_IDLE: begin
        if (clr_req) begin
          state_d = RAM_CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = RAM_CLEAR;
    endcase
  end

endmodule

// File: rtl/ram_mp.sv
// rtl/ram_mp.sv - byte-enabled RAM with one write port, RD_PORTS read ports and a clear engine
module ram_mp
  import ram_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WORD_SIZE = 8,
  parameter int RD_PORTS  = 2,
  parameter int BYTE_W    = 8,
  parameter bit REG_OUT   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_req,
  output logic                          busy,
  input  logic                          wr_en,
  input  logic [WORD_SIZE-1:0]          wr_addr,
  input  logic [WIDTH/BYTE_W-1:0]       wr_be,
  input  logic [WIDTH-1:0]              data_in,
  input  logic [RD_PORTS-1:0]           rd_en,
  input  logic [RD_PORTS*WORD_SIZE-1:0] rd_addr,
  output logic [RD_PORTS*WIDTH-1:0]     data_out,
  output logic [RD_PORTS-1:0]           rd_valid
);

  localparam int DEPTH = 2**WORD_SIZE;

  if (ram_lanes(WIDTH, BYTE_W) * BYTE_W != WIDTH) begin : g_bad_width
    $error("ram_mp: WIDTH must be a multiple of BYTE_W");
  end
  if (RD_PORTS < 1) begin : g_bad_ports
    $error("ram_mp: RD_PORTS must be at least 1");
  end
  if (WIDTH > RAM_MAX_W) begin : g_too_wide
    $error("ram_mp: WIDTH exceeds RAM_MAX_W");
  end

  logic                 busy_w;
  logic                 clr_we;
  logic [WORD_SIZE-1:0] clr_addr;

  ram_clr_ctrl #(.WORD_SIZE(WORD_SIZE)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy_w),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign busy = busy_w;

  logic [WIDTH-1:0]                   mem_q [DEPTH];
  logic [RD_PORTS-1:0][WORD_SIZE-1:0] rd_addr_a;
  logic [WIDTH-1:0]                   merged;
  logic                               mem_we;
  logic [WORD_SIZE-1:0]               mem_addr;
  logic [WIDTH-1:0]                   mem_wdata;

  assign rd_addr_a = rd_addr;

  // The clear engine owns the array while busy; user writes are simply dropped.
  always_comb begin
    merged = WIDTH'(byte_merge(RAM_MAX_W'(mem_q[wr_addr]), RAM_MAX_W'(data_in),
                               RAM_MAX_W'(wr_be), BYTE_W));
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end else begin
      mem_we    = wr_en & (|wr_be);
      mem_addr  = wr_addr;
      mem_wdata = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  if (REG_OUT) begin : g_reg_out
    logic [RD_PORTS-1:0][WIDTH-1:0] dout_q, dout_d;
    logic [RD_PORTS-1:0]            valid_q, valid_d;

    // Write-first: a read hitting the word being written returns the merged word.
    always_comb begin
      dout_d  = dout_q;
      valid_d = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rd_en[p] && !busy_w) begin
          valid_d[p] = 1'b1;
          dout_d[p]  = (wr_en && rd_addr_a[p] == wr_addr) ? merged : mem_q[rd_addr_a[p]];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= '0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = valid_q;
  end else begin : g_async_out
    logic [RD_PORTS-1:0][WIDTH-1:0] dout_c;

    always_comb begin
      dout_c = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
        dout_c[p] = mem_q[rd_addr_a[p]];
      end
    end

    assign data_out = dout_c;
    assign rd_valid = rd_en & {RD_PORTS{~busy_w}};
  end

endmodule
